agu_param: RTL and testbench



---
 rtl/agu_param.sv | 98 +++++++++
 tb/tb_agu_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/agu_param.sv
// agu_param: NTT butterfly address generator issuing 2^RADIX_BITS lane addresses per beat with valid/ready flow.
// A final partial radix digit (LOGN not a multiple of RADIX_BITS) is anchored at bit 0 so every stage still covers 0..N-1.
module agu_param #(
  parameter int LOGN = 10,
  parameter int RADIX_BITS = 4,
  localparam int K = (LOGN + RADIX_BITS - 1) / RADIX_BITS,
  localparam int STW = (K > 1) ? $clog2(K) : 1,
  localparam int LANES = 1 << RADIX_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    inv_i,
  input  logic                    out_ready_i,
  output logic                    out_valid_o,
  output logic [LANES*LOGN-1:0]   addr_o,
  output logic [STW-1:0]          stage_o,
  output logic [LOGN-1:0]         tw_idx_o,
  output logic                    busy_o,
  output logic                    done_o
);
  localparam int R = RADIX_BITS;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                  state_q;
  logic                    inv_q, valid_q, busy_q, done_q;
  logic [STW-1:0]          l_q, stage_q;
  logic [LOGN-1:0]         i_q, j_q, tw_q;
  logic [LANES*LOGN-1:0]   addr_q, addr_d;
  logic [LOGN-1:0]         i_max, j_max, rev_full, rev_j;
  logic                    i_last, j_last, l_last, load;
  int                      lo;
  // lo is the bit position of this stage's radix digit; j occupies the bits above it, i those below.
  always_comb begin
    lo = (LOGN > R * (int'(l_q) + 1)) ? LOGN - R * (int'(l_q) + 1) : 0;
    i_max = LOGN'((1 << lo) - 1);
    j_max = LOGN'((1 << (LOGN - R - lo)) - 1);
    rev_full = '0;
    for (int b = 0; b < LOGN; b++) rev_full[LOGN-1-b] = j_q[b];
    rev_j = rev_full >> (lo + R);
    addr_d = '0;
    for (int m = 0; m < LANES; m++)
      addr_d[m*LOGN +: LOGN] = (rev_j << (lo + R)) + (LOGN'(m) << lo) + i_q;
    i_last = i_q == i_max;
    j_last = j_q == j_max;
    l_last = inv_q ? (l_q == '0) : (l_q == STW'(K - 1));
    load = !valid_q || out_ready_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      inv_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      l_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      stage_q <= '0;
      tw_q    <= '0;
      addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i && !done_q) begin
          state_q <= RUN;
          inv_q   <= inv_i;
          l_q     <= inv_i ? STW'(K - 1) : '0;
          i_q     <= '0;
          j_q     <= '0;
          busy_q  <= 1'b1;
        end
        RUN: if (load) begin
          addr_q  <= addr_d;
          stage_q <= l_q;
          tw_q    <= rev_j;
          valid_q <= 1'b1;
          i_q     <= i_last ? '0 : i_q + 1'b1;
          if (i_last) j_q <= j_last ? '0 : j_q + 1'b1;
          if (i_last && j_last && !l_last) l_q <= inv_q ? l_q - 1'b1 : l_q + 1'b1;
          if (i_last && j_last && l_last) state_q <= DRAIN;
        end
        DRAIN: if (valid_q && out_ready_i) begin
          valid_q <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign out_valid_o = valid_q;
  assign addr_o      = addr_q;
  assign stage_o     = stage_q;
  assign tw_idx_o    = tw_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
endmodule

// File: tb/tb_agu_param.sv
// tb_agu_param: directed sweeps of a 16-point radix-4 instance against a loop-nest reference, plus a coverage scoreboard on the default instance.
module tb_agu_param;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic s_start = 1'b0, s_inv = 1'b0, s_ready = 1'b0;
  logic s_valid, s_busy, s_done;
  logic [15:0] s_addr;
  logic [0:0]  s_stage;
  logic [3:0]  s_tw;
  agu_param #(.LOGN(4), .RADIX_BITS(2)) u_s (
    .clk(clk), .rst(rst), .start_i(s_start), .inv_i(s_inv), .out_ready_i(s_ready),
    .out_valid_o(s_valid), .addr_o(s_addr), .stage_o(s_stage), .tw_idx_o(s_tw),
    .busy_o(s_busy), .done_o(s_done));

  logic d_start = 1'b0, d_inv = 1'b0, d_ready = 1'b0;
  logic d_valid, d_busy, d_done;
  logic [159:0] d_addr;
  logic [1:0]   d_stage;
  logic [9:0]   d_tw;
  agu_param u_d (
    .clk(clk), .rst(rst), .start_i(d_start), .inv_i(d_inv), .out_ready_i(d_ready),
    .out_valid_o(d_valid), .addr_o(d_addr), .stage_o(d_stage), .tw_idx_o(d_tw),
    .busy_o(d_busy), .done_o(d_done));

  int checks = 0, errors = 0;
  logic [15:0] ex_a[$];
  int ex_s[$], ex_t[$];
  int cnt[3][1024];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rev_bits(input int v, input int w);
    int r = 0;
    for (int b = 0; b < w; b++) r = (r << 1) | ((v >> b) & 1);
    return r;
  endfunction

  // Reference beat list for N=16, radix 4, written straight from the l/j/i loop nest.
  task automatic build(input logic iv);
    ex_a.delete(); ex_s.delete(); ex_t.delete();
    for (int s = 0; s < 2; s++) begin
      int l = iv ? 1 - s : s;
      for (int j = 0; j < (1 << (2 * l)); j++)
        for (int i = 0; i < (1 << (4 - 2 * (l + 1))); i++) begin
          logic [15:0] a;
          for (int m = 0; m < 4; m++)
            a[m*4 +: 4] = 4'(rev_bits(j, 2 * l) * (1 << (4 - 2 * l)) + m * (1 << (4 - 2 * (l + 1))) + i);
          ex_a.push_back(a);
          ex_s.push_back(l);
          ex_t.push_back(rev_bits(j, 2 * l));
        end
    end
  endtask

  task automatic sweep(input logic iv, input bit rnd, input int poke, input string tag);
    int n = 0, cyc = 0;
    logic hs = 1'b0, held = 1'b0;
    logic [15:0] ha = '0;
    logic [0:0] hg = '0;
    logic [3:0] ht = '0;
    build(iv);
    s_inv = iv; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; s_inv = ~iv;
    check({tag, "_busy"}, 64'(s_busy), 64'd1);
    check({tag, "_latency"}, 64'(s_valid), 64'd0);
    while (!s_done && cyc < 300) begin
      s_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_start = (n == poke);
      if (held) begin
        check({tag, "_hold_valid"}, 64'(s_valid), 64'd1);
        check({tag, "_hold_addr"}, 64'(s_addr), 64'(ha));
        check({tag, "_hold_meta"}, 64'({s_stage, s_tw}), 64'({hg, ht}));
      end
      hs = s_valid && s_ready;
      if (hs) begin
        if (n < 8) begin
          check($sformatf("%s_addr%0d", tag, n), 64'(s_addr), 64'(ex_a[n]));
          check($sformatf("%s_stage%0d", tag, n), 64'(s_stage), 64'(ex_s[n]));
          check($sformatf("%s_tw%0d", tag, n), 64'(s_tw), 64'(ex_t[n]));
        end
        n++;
      end
      held = s_valid && !s_ready;
      ha = s_addr; hg = s_stage; ht = s_tw;
      @(posedge clk); #1;
      cyc++;
      if (s_done) check({tag, "_done_timing"}, 64'({hs, 8'(n)}), 64'({1'b1, 8'd8}));
    end
    check({tag, "_done_seen"}, 64'(s_done), 64'd1);
    check({tag, "_beats"}, 64'(n), 64'd8);
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    check({tag, "_done_pulse"}, 64'(s_done), 64'd0);
    check({tag, "_idle_after"}, 64'({s_busy, s_valid}), 64'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #18;
    check("rst_small", 64'({s_valid, s_busy, s_done, s_addr, s_stage, s_tw}), 64'd0);
    check("rst_default_addr", 64'(d_addr[63:0] | d_addr[159:64]), 64'd0);
    check("rst_default_ctl", 64'({d_valid, d_busy, d_done, d_stage, d_tw}), 64'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    sweep(1'b0, 1'b0, -1, "fwd");
    sweep(1'b1, 1'b0, -1, "inv");
    sweep(1'b0, 1'b1, -1, "rnd_ready");
    sweep(1'b0, 1'b0, 3, "start_busy");

    begin
      int n = 0, cyc = 0;
      s_inv = 1'b0; s_start = 1'b1; s_ready = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      while (n < 5 && cyc < 50) begin
        if (s_valid) n++;
        @(posedge clk); #1;
        cyc++;
      end
      check("rst_mid_reached", 64'(n), 64'd5);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_outputs", 64'({s_valid, s_busy, s_done, s_addr, s_stage, s_tw}), 64'd0);
      #2 rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        check("rst_mid_no_done", 64'({s_done, s_valid, s_busy}), 64'd0);
      end
    end
    sweep(1'b0, 1'b0, -1, "after_rst");

    begin
      int n = 0, cyc = 0, bad = 0;
      for (int s = 0; s < 3; s++) for (int a = 0; a < 1024; a++) cnt[s][a] = 0;
      d_inv = 1'b0; d_start = 1'b1;
      @(posedge clk); #1;
      d_start = 1'b0;
      while (!d_done && cyc < 2000) begin
        d_ready = 1'($urandom_range(0, 1));
        if (d_valid && d_ready) begin
          if (int'(d_stage) != n / 64) bad++;
          if (d_stage < 2'd3)
            for (int m = 0; m < 16; m++) cnt[d_stage][d_addr[m*10 +: 10]]++;
          n++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      check("def_done_seen", 64'(d_done), 64'd1);
      check("def_beats", 64'(n), 64'd192);
      check("def_stage_order", 64'(bad), 64'd0);
      for (int s = 0; s < 3; s++) begin
        bad = 0;
        for (int a = 0; a < 1024; a++) if (cnt[s][a] != 1) bad++;
        check($sformatf("def_cover_stage%0d", s), 64'(bad), 64'd0);
      end
      @(posedge clk); #1;
      check("def_idle_after", 64'({d_busy, d_done, d_valid}), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
